// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
package matmul_pkg;

    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] rm_index(input int r, input int c, input int cols);
        return ADDR_W'(r * cols + c);
    endfunction

    // Accumulator wide enough for a full-length dot product of max-valued operands.
    function automatic int out_size(input int size, input int cols);
        return 2 * size + $clog2(cols);
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac.sv
// Multiply-accumulate register: clear has priority over accumulate.
module mac_unit #(
    parameter int SIZE     = 8,
    parameter int OUT_SIZE = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [SIZE-1:0]     a_i,
    input  logic [SIZE-1:0]     b_i,
    output logic [OUT_SIZE-1:0] acc_o
);

    logic [2*SIZE-1:0]   prod;
    logic [OUT_SIZE-1:0] acc_q, acc_d;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + OUT_SIZE'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences A/B element fetches, MACs each dot product and writes C row-major.
// Build option MATMUL_SAT_EN clamps written results to the SIZE-bit maximum.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | one-cycle read strobe for A(i,k), B(k,j)
// MAC   | accumulate a_data*b_data, advance k
// WRITE | write acc to C(i,j), advance j/i
// DONE  | one-cycle done pulse
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int ROW      = 2,
    parameter int COLUMN   = 2,
    parameter int SIZE     = 8,
    parameter int OUT_SIZE = out_size(SIZE, COLUMN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                a_read,
    output logic [ADDR_W-1:0]   a_read_address,
    input  logic [SIZE-1:0]     a_data,
    output logic                b_read,
    output logic [ADDR_W-1:0]   b_read_address,
    input  logic [SIZE-1:0]     b_data,
    output logic                c_write,
    output logic [ADDR_W-1:0]   c_write_address,
    output logic [OUT_SIZE-1:0] c_write_value
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [OUT_SIZE-1:0] acc, wr_value;
    logic                last_k, last_elem, mac_clr, mac_en;

    assign last_k    = (k_q == ADDR_W'(COLUMN - 1));
    assign last_elem = (i_q == ADDR_W'(ROW - 1)) && (j_q == ADDR_W'(COLUMN - 1));
    assign mac_clr   = ((state_q == ST_IDLE) && start) || (state_q == ST_WRITE);
    assign mac_en    = (state_q == ST_MAC);

    mac_unit #(.SIZE(SIZE), .OUT_SIZE(OUT_SIZE)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (a_data),
        .b_i   (b_data),
        .acc_o (acc)
    );

`ifdef MATMUL_SAT_EN
    localparam logic [OUT_SIZE-1:0] SAT_MAX = {{(OUT_SIZE-SIZE){1'b0}}, {SIZE{1'b1}}};
    assign wr_value = (acc > SAT_MAX) ? SAT_MAX : acc;
`else
    assign wr_value = acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_FETCH;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
            end
            ST_FETCH: state_d = ST_MAC;
            ST_MAC: begin
                if (last_k) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_FETCH;
                    k_d     = k_q + ADDR_W'(1);
                end
            end
            ST_WRITE: begin
                state_d = last_elem ? ST_DONE : ST_FETCH;
                k_d     = '0;
                if (j_q == ADDR_W'(COLUMN - 1)) begin
                    j_d = '0;
                    i_d = i_q + ADDR_W'(1);
                end else begin
                    j_d = j_q + ADDR_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses and value are forced to zero outside their strobe cycle.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        done            = 1'b0;
        a_read          = 1'b0;
        b_read          = 1'b0;
        a_read_address  = '0;
        b_read_address  = '0;
        c_write         = 1'b0;
        c_write_address = '0;
        c_write_value   = '0;
        case (state_q)
            ST_FETCH: begin
                a_read         = 1'b1;
                b_read         = 1'b1;
                a_read_address = rm_index(int'(i_q), int'(k_q), COLUMN);
                b_read_address = rm_index(int'(k_q), int'(j_q), COLUMN);
            end
            ST_WRITE: begin
                c_write         = 1'b1;
                c_write_address = rm_index(int'(i_q), int'(j_q), COLUMN);
                c_write_value   = wr_value;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: edge-triggered memory models, cycle-level reference model, random matrices.
module tb_matmul_sequencer;

    localparam int ROW      = 2;
    localparam int COLUMN   = 2;
    localparam int SIZE     = 8;
    localparam int OUT_SIZE = 17;
    localparam int N        = ROW * COLUMN;
    localparam int EL       = 2 * COLUMN + 1;
    localparam int TOTAL    = N * EL;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                busy, done, a_read, b_read, c_write;
    logic [5:0]          a_read_address, b_read_address, c_write_address;
    logic [SIZE-1:0]     a_data = '0, b_data = '0;
    logic [OUT_SIZE-1:0] c_write_value;

    matmul_sequencer #(.ROW(ROW), .COLUMN(COLUMN), .SIZE(SIZE), .OUT_SIZE(OUT_SIZE)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .a_read          (a_read),
        .a_read_address  (a_read_address),
        .a_data          (a_data),
        .b_read          (b_read),
        .b_read_address  (b_read_address),
        .b_data          (b_data),
        .c_write         (c_write),
        .c_write_address (c_write_address),
        .c_write_value   (c_write_value)
    );

    always #5 clk = ~clk;

    logic [SIZE-1:0] mem_a [64];
    logic [SIZE-1:0] mem_b [64];
    logic            a_prev = 1'b0, b_prev = 1'b0;

    // Memories update only on a rising strobe.
    always @(posedge clk) begin
        if (a_read && !a_prev) a_data <= mem_a[a_read_address];
        if (b_read && !b_prev) b_data <= mem_b[b_read_address];
        a_prev <= a_read;
        b_prev <= b_read;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    longint exp_c [N];

    task automatic compute_expected();
        longint sum;
        for (int i = 0; i < ROW; i++)
            for (int j = 0; j < COLUMN; j++) begin
                sum = 0;
                for (int k = 0; k < COLUMN; k++)
                    sum += longint'(mem_a[i*COLUMN+k]) * longint'(mem_b[k*COLUMN+j]);
`ifdef MATMUL_SAT_EN
                if (sum > 255) sum = 255;
`endif
                exp_c[i*COLUMN+j] = sum;
            end
    endtask

    task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
        mem_a[0] = SIZE'(a0); mem_a[1] = SIZE'(a1); mem_a[2] = SIZE'(a2); mem_a[3] = SIZE'(a3);
        mem_b[0] = SIZE'(b0); mem_b[1] = SIZE'(b1); mem_b[2] = SIZE'(b2); mem_b[3] = SIZE'(b3);
        compute_expected();
    endtask

    // Reference timing: m_cyc counts clock edges with the start-sampling edge as 1.
    bit m_active = 0;
    int m_cyc    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            m_cyc    = 0;
        end else if (m_active) begin
            if (m_cyc == TOTAL + 1) begin
                m_active = 0;
                m_cyc    = 0;
            end else begin
                m_cyc++;
            end
        end else if (start) begin
            m_active = 1;
            m_cyc    = 1;
        end
    end

    bit chk_en = 0;
    bit prev_ar = 0, prev_br = 0;
    int rd_cnt = 0, wr_cnt = 0;
    int ph, el, ki, ii, jj;
    bit x_fetch, x_write, x_done;

    always @(negedge clk) begin
        if (chk_en) begin
            x_fetch = 0; x_write = 0; x_done = 0;
            ph = 0; el = 0;
            if (m_active) begin
                ph      = (m_cyc - 1) % EL;
                el      = (m_cyc - 1) / EL;
                x_fetch = (m_cyc <= TOTAL) && (ph < 2 * COLUMN) && (ph % 2 == 0);
                x_write = (m_cyc <= TOTAL) && (ph == 2 * COLUMN);
                x_done  = (m_cyc == TOTAL + 1);
            end
            ki = ph / 2;
            ii = el / COLUMN;
            jj = el % COLUMN;
            if (m_active && m_cyc == 1) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end
            check("busy", busy, m_active);
            check("done", done, x_done);
            check("a_read", a_read, x_fetch);
            check("b_read", b_read, x_fetch);
            check("c_write", c_write, x_write);
            check("a_read_back_to_back", a_read && prev_ar, 0);
            check("b_read_back_to_back", b_read && prev_br, 0);
            if (x_fetch) begin
                check("a_read_address", a_read_address, ii * COLUMN + ki);
                check("b_read_address", b_read_address, ki * COLUMN + jj);
            end
            if (x_write) begin
                check("c_write_address", c_write_address, el);
                check("c_write_value", c_write_value, exp_c[el]);
            end
            if (a_read) rd_cnt++;
            if (c_write) wr_cnt++;
            if (x_done) begin
                check("read_pulses_per_run", rd_cnt, N * COLUMN);
                check("write_pulses_per_run", wr_cnt, N);
            end
        end
        prev_ar = a_read;
        prev_br = b_read;
    end

    task automatic run_mm(input bit poke_start);
        int n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (poke_start && n == 7) start = 1'b1;
            if (poke_start && n == 8) start = 1'b0;
        end
        check("done_latency", n, TOTAL + 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_a_read"}, a_read, 0);
        check({tag, "_b_read"}, b_read, 0);
        check({tag, "_c_write"}, c_write, 0);
        check({tag, "_a_addr"}, a_read_address, 0);
        check({tag, "_b_addr"}, b_read_address, 0);
        check({tag, "_c_addr"}, c_write_address, 0);
        check({tag, "_c_value"}, c_write_value, 0);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        exp_c = '{default: 0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk);

        load(10, 3, 255, 63, 10, 3, 255, 63);
`ifdef MATMUL_SAT_EN
        check("pin_sq_c0", exp_c[0], 255);
        check("pin_sq_c1", exp_c[1], 219);
        check("pin_sq_c2", exp_c[2], 255);
        check("pin_sq_c3", exp_c[3], 255);
`else
        check("pin_sq_c0", exp_c[0], 865);
        check("pin_sq_c1", exp_c[1], 219);
        check("pin_sq_c2", exp_c[2], 18615);
        check("pin_sq_c3", exp_c[3], 4734);
`endif
        run_mm(1'b1);

        load(10, 3, 255, 63, 1, 0, 0, 1);
        check("pin_id_c0", exp_c[0], 10);
        check("pin_id_c1", exp_c[1], 3);
        check("pin_id_c2", exp_c[2], 255);
        check("pin_id_c3", exp_c[3], 63);
        run_mm(1'b0);

        load(255, 255, 255, 255, 255, 255, 255, 255);
`ifdef MATMUL_SAT_EN
        check("pin_max_c0", exp_c[0], 255);
`else
        check("pin_max_c0", exp_c[0], 130050);
`endif
        run_mm(1'b0);

        // Reset during the third element's first MAC cycle.
        load(7, 9, 200, 17, 33, 250, 4, 128);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (!(m_active && m_cyc == 2 * EL + 2) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("reach_third_mac", guard < 40, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        repeat (30) @(negedge clk);

        // start together with rst must not launch a run.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", busy, 0);
        run_mm(1'b0);

        for (int r = 0; r < 5; r++) begin
            load($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
            run_mm(r[0]);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
